midi_tx_encoder: RTL and testbench

Builds MIDI channel-voice messages from parallel event fields and serialises them onto a MIDI OUT line (8N1 UART, LSB first, 31250 baud).
- Transmit counterpart of the note/CC parser on the MIDI input side; sits between the synth control logic and the physical MIDI OUT pin.
- Running-status compression is optional.
- Accepts one event at a time over a valid/ready handshake.

---
 rtl/midi_tx_encoder.sv | 164 ++++++++++++++++
 tb/tb_midi_tx_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/midi_tx_encoder.sv
// MIDI channel-voice message encoder and 8N1 serialiser for the MIDI OUT line.
// One event at a time is accepted over valid/ready. The message (1..3 bytes) is
// built at acceptance and then shifted out LSB first. The status byte is dropped
// when it matches the last status sent, if running status is enabled.
module midi_tx_encoder #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned BAUD           = 31250,
    parameter int unsigned RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [3:0] msg_type,
    input  logic [3:0] chan,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    output logic       midi_tx,
    output logic       busy,
    output logic       err
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        last_q, last_d;     // index of the final byte of the message
    logic [2:0][7:0]   bytes_q, bytes_d;
    logic [7:0]        status_q, status_d;
    logic              status_vld_q, status_vld_d;
    logic              err_q, err_d;

    logic              type_ok;
    logic              two_data;
    logic [7:0]        status_new;
    logic              drop_status;

    assign type_ok     = msg_type[3] && (msg_type != 4'hF);
    assign two_data    = (msg_type != 4'hC) && (msg_type != 4'hD);
    assign status_new  = {msg_type, chan};
    assign drop_status = (RUNNING_STATUS != 0) && status_vld_q && (status_q == status_new);

    // Next-state: acceptance builds the byte list, then start/data/stop bit timing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        idx_d        = idx_q;
        last_d       = last_q;
        bytes_d      = bytes_q;
        status_d     = status_q;
        status_vld_d = status_vld_q;
        err_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_valid) begin
                    if (!type_ok) begin
                        // Invalid type is consumed silently apart from the err pulse.
                        err_d = 1'b1;
                    end else begin
                        status_d     = status_new;
                        status_vld_d = 1'b1;
                        idx_d        = 2'd0;
                        cnt_d        = '0;
                        bit_d        = 3'd0;
                        state_d      = StStart;
                        if (drop_status) begin
                            bytes_d[0] = {1'b0, data1};
                            bytes_d[1] = {1'b0, data2};
                            bytes_d[2] = 8'h00;
                            last_d     = two_data ? 2'd1 : 2'd0;
                        end else begin
                            bytes_d[0] = status_new;
                            bytes_d[1] = {1'b0, data1};
                            bytes_d[2] = {1'b0, data2};
                            last_d     = two_data ? 2'd2 : 2'd1;
                        end
                    end
                end
            end
            StStart: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (idx_q == last_q) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StStart;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset also forgets running status so the next message carries it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            idx_q        <= 2'd0;
            last_q       <= 2'd0;
            bytes_q      <= '0;
            status_q     <= 8'h00;
            status_vld_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            bytes_q      <= bytes_d;
            status_q     <= status_d;
            status_vld_q <= status_vld_d;
            err_q        <= err_d;
        end
    end

    // Line level decoded from state so reset returns it high immediately.
    always_comb begin
        midi_tx = 1'b1;
        unique case (state_q)
            StStart: midi_tx = 1'b0;
            StData:  midi_tx = bytes_q[idx_q][bit_q];
            default: midi_tx = 1'b1;
        endcase
    end

    assign ev_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Directed bench for midi_tx_encoder with a reduced baud divider (DIV = 16).
// Instance u_rs has running status enabled, u_nrs has it disabled.
module tb_midi_tx_encoder;

    localparam int unsigned DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] msg_type;
    logic [3:0] chan;
    logic [6:0] data1;
    logic [6:0] data2;
    logic       ev_valid, ev_ready, midi_tx, busy, err;
    logic       ev_valid2, ev_ready2, midi_tx2, busy2, err2;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    midi_tx_encoder #(.CLK_HZ(500000), .BAUD(31250), .RUNNING_STATUS(1)) u_rs (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .msg_type(msg_type), .chan(chan), .data1(data1), .data2(data2),
        .midi_tx(midi_tx), .busy(busy), .err(err)
    );

    midi_tx_encoder #(.CLK_HZ(500000), .BAUD(31250), .RUNNING_STATUS(0)) u_nrs (
        .clk(clk), .rst(rst), .ev_valid(ev_valid2), .ev_ready(ev_ready2),
        .msg_type(msg_type), .chan(chan), .data1(data1), .data2(data2),
        .midi_tx(midi_tx2), .busy(busy2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] obs3(input bit sel);
        return sel ? {busy2, ev_ready2, midi_tx2} : {busy, ev_ready, midi_tx};
    endfunction

    // Present an event and wait for the accepting edge; returns 1 time unit after it.
    task automatic drive(input bit sel, input logic [3:0] t, input logic [3:0] c,
                         input logic [6:0] d1, input logic [6:0] d2, input bit hold);
        bit rdy;
        bit got = 0;
        @(negedge clk);
        msg_type = t; chan = c; data1 = d1; data2 = d2;
        if (sel) ev_valid2 = 1'b1; else ev_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            rdy = sel ? ev_ready2 : ev_ready;
            @(posedge clk);
            if (rdy) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        #1;
        if (!hold) begin
            if (sel) ev_valid2 = 1'b0; else ev_valid = 1'b0;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Check every cycle of an n-byte message, then the idle cycle after it.
    task automatic check_frames(input string tag, input bit sel, input int n,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2);
        logic [7:0] bl [3];
        int bad = 0;
        logic [2:0] first_obs = 3'b000;
        logic [2:0] first_exp = 3'b000;
        logic [7:0] b;
        int pos;
        logic e;
        bl[0] = b0; bl[1] = b1; bl[2] = b2;
        for (int k = 0; k < n * 10 * DIV; k++) begin
            @(negedge clk);
            b   = bl[k / (10 * DIV)];
            pos = (k % (10 * DIV)) / DIV;
            if (pos == 0)      e = 1'b0;
            else if (pos == 9) e = 1'b1;
            else               e = b[pos - 1];
            if (obs3(sel) !== {1'b1, 1'b0, e}) begin
                if (bad == 0) begin
                    first_obs = obs3(sel);
                    first_exp = {1'b1, 1'b0, e};
                end
                bad++;
            end
        end
        chk({tag, "_bad_cycles"}, bad, 0);
        if (bad != 0) chk({tag, "_first_bad"}, first_obs, first_exp);
        @(negedge clk);
        chk({tag, "_idle_after"}, obs3(sel), 3'b011);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ev_valid = 1'b0; ev_valid2 = 1'b0;
        msg_type = 4'h0; chan = 4'h0; data1 = 7'h0; data2 = 7'h0;
        #23;
        chk("reset_outputs", {busy, ev_ready, midi_tx, err}, 4'b0110);
        chk("reset_outputs_nrs", {busy2, ev_ready2, midi_tx2, err2}, 4'b0110);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // NoteOn ch3: full message after reset
        drive(0, 4'h9, 4'h3, 7'd60, 7'd100, 0);
        check_frames("noteon_first", 0, 3, 8'h93, 8'h3C, 8'h64);

        // Same status again: running status drops it
        drive(0, 4'h9, 4'h3, 7'd64, 7'd64, 0);
        check_frames("noteon_running", 0, 2, 8'h40, 8'h40, 8'h00);

        // ProgChg: two bytes, data2 never sent
        drive(0, 4'hC, 4'h0, 7'd5, 7'h7F, 0);
        check_frames("progchg", 0, 2, 8'hC0, 8'h05, 8'h00);

        // Invalid types: err pulse for one cycle, line untouched
        drive(0, 4'hF, 4'h0, 7'd1, 7'd2, 0);
        @(negedge clk);
        chk("err_f_pulse", {err, busy, ev_ready, midi_tx}, 4'b1011);
        @(negedge clk);
        chk("err_f_clear", {err, busy, ev_ready, midi_tx}, 4'b0011);
        drive(0, 4'h3, 4'h0, 7'd1, 7'd2, 0);
        @(negedge clk);
        chk("err_low_pulse", {err, busy, ev_ready, midi_tx}, 4'b1011);
        @(negedge clk);
        chk("err_low_clear", {err, busy, ev_ready, midi_tx}, 4'b0011);

        // Last status still C0 after the invalid events
        drive(0, 4'hC, 4'h0, 7'd7, 7'd0, 0);
        check_frames("progchg_running", 0, 1, 8'h07, 8'h00, 8'h00);
        drive(0, 4'h9, 4'h3, 7'd60, 7'd100, 0);
        check_frames("noteon_after_err", 0, 3, 8'h93, 8'h3C, 8'h64);

        // Reset mid-frame: running-status message (3C 64), cut during bit0 of 3C
        drive(0, 4'h9, 4'h3, 7'd60, 7'd100, 0);
        repeat (20) @(negedge clk);
        chk("pre_reset_line", {busy, midi_tx}, 2'b10);
        #1 rst = 1'b0;
        #1;
        chk("mid_reset_outputs", {busy, ev_ready, midi_tx}, 3'b011);
        @(negedge clk); rst = 1'b1;
        drive(0, 4'h9, 4'h3, 7'd60, 7'd100, 0);
        check_frames("noteon_after_reset", 0, 3, 8'h93, 8'h3C, 8'h64);

        // Back-to-back with ev_valid held high
        drive(0, 4'hB, 4'h5, 7'd7, 7'd100, 1);
        msg_type = 4'h8; chan = 4'h5; data1 = 7'd60; data2 = 7'd0;
        check_frames("b2b_first", 0, 3, 8'hB5, 8'h07, 8'h64);
        @(posedge clk);
        #1 ev_valid = 1'b0;
        check_frames("b2b_second", 0, 3, 8'h85, 8'h3C, 8'h00);

        // Running status disabled: status byte always sent
        drive(1, 4'h9, 4'h3, 7'd60, 7'd100, 0);
        check_frames("nrs_first", 1, 3, 8'h93, 8'h3C, 8'h64);
        drive(1, 4'h9, 4'h3, 7'd64, 7'd64, 0);
        check_frames("nrs_repeat", 1, 3, 8'h93, 8'h40, 8'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
